// File: rtl/seqdet_sched.sv
// seqdet_sched: round-robin front end that time-shares one serial Moore
// sequence detector among N_REQ requesters. A granted word is shifted into
// the detector LSB-first after a one-cycle clear. The number of bit-times
// with q=1 and the final q are then returned through a result handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. ready may depend combinationally on valid. A source holds
// valid and its payload stable until that edge. res_* stays stable while
// res_valid is high and res_ready is low.
module seqdet_sched #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ID_W   = 2,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    det_clr,
    output logic                    w_out,
    input  logic                    q_in,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [CNT_W-1:0]        res_count,
    output logic                    res_final_q,
    output logic                    busy,
    output logic [2:0]              dbg_state
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_grant_found;
    logic               w_accept;
    int                 w_sum;
    logic [DATA_W-1:0]  r_word;
    logic [BIT_W-1:0]   r_bit;
    logic [CNT_W-1:0]   r_cnt;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_res_id;
    logic [CNT_W-1:0]   r_res_count;
    logic               r_res_final_q;

    // Rotating priority search: first valid requester at or after r_rr_ptr.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_sum         = 0;
        for (int j = 0; j < N_REQ; j++) begin
            w_sum = int'(r_rr_ptr) + j;
            if (w_sum >= N_REQ) begin
                w_sum = w_sum - N_REQ;
            end
            if (!w_grant_found && req_valid[ID_W'(w_sum)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = ID_W'(w_sum);
            end
        end
    end

    // One-hot grant, only offered in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_grant_found && Reset) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_accept = |(req_valid & req_ready);

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next    = r_state;
        det_clr   = 1'b0;
        w_out     = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_next = S_CLR;
                end
            end
            S_CLR: begin
                det_clr = 1'b1;
                w_next  = S_SHIFT;
            end
            S_SHIFT: begin
                w_out = r_word[0];
                if (r_bit == BIT_W'(DATA_W - 1)) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, serialize, count hits, load result.
    // The q sampled in SHIFT cycle k answers bit k-1, so k=0 is skipped and
    // the answer to the last bit is picked up in WAIT.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_rr_ptr      <= '0;
            r_word        <= '0;
            r_bit         <= '0;
            r_cnt         <= '0;
            r_id          <= '0;
            r_res_id      <= '0;
            r_res_count   <= '0;
            r_res_final_q <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_word   <= req_data[w_grant_idx*DATA_W +: DATA_W];
                        r_id     <= w_grant_idx;
                        r_rr_ptr <= (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
                    end
                end
                S_CLR: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                end
                S_SHIFT: begin
                    r_word <= r_word >> 1;
                    r_bit  <= r_bit + 1'b1;
                    if (r_bit != '0 && q_in) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    r_res_count   <= r_cnt + CNT_W'(q_in);
                    r_res_final_q <= q_in;
                    r_res_id      <= r_id;
                end
                default: begin
                end
            endcase
        end
    end

    assign res_id      = r_res_id;
    assign res_count   = r_res_count;
    assign res_final_q = r_res_final_q;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_seqdet_sched.sv
// Bench for seqdet_sched with a behavioural model of the detector attached
// (A:0->B,1->F; B:0->C; C:0->C; F:0->B; any 1->F; q=1 in C and F).
module tb_seqdet_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int CW = 4;
  localparam int SB_W = IW + CW + 1;

  localparam logic [1:0] ST_A = 2'd0;
  localparam logic [1:0] ST_B = 2'd1;
  localparam logic [1:0] ST_C = 2'd2;
  localparam logic [1:0] ST_F = 2'd3;

  logic            clk = 1'b0;
  logic            Reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            det_clr;
  logic            w_out;
  logic            q_in;
  logic            res_valid;
  logic            res_ready;
  logic [IW-1:0]   res_id;
  logic [CW-1:0]   res_count;
  logic            res_final_q;
  logic            busy;
  logic [2:0]      dbg_state;

  int total = 0;
  int bad   = 0;
  int tb_ptr = 0;
  logic [DW-1:0] d [N];
  logic [SB_W-1:0] exp_q[$];

  seqdet_sched #(.N_REQ(N), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .det_clr(det_clr), .w_out(w_out), .q_in(q_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_count(res_count), .res_final_q(res_final_q), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset-independent clock generator
  always #5 clk = ~clk;

  // detector model
  function automatic logic [1:0] det_next(input logic [1:0] s, input logic w);
    if (w) return ST_F;
    case (s)
      ST_A:    return ST_B;
      ST_B:    return ST_C;
      ST_C:    return ST_C;
      default: return ST_B;
    endcase
  endfunction

  logic [1:0] det_st;
  always @(posedge clk or negedge Reset) begin
    if (!Reset)       det_st <= ST_A;
    else if (det_clr) det_st <= ST_A;
    else              det_st <= det_next(det_st, w_out);
  end
  assign q_in = (det_st == ST_C) || (det_st == ST_F);

  // reference: walk the word through the detector rules, count q=1 bit-times
  function automatic logic [CW:0] ref_det(input logic [DW-1:0] word);
    logic [1:0] s;
    int c;
    logic q;
    s = ST_A; c = 0; q = 1'b0;
    for (int b = 0; b < DW; b++) begin
      s = det_next(s, word[b]);
      q = (s == ST_C) || (s == ST_F);
      c += int'(q);
    end
    return {CW'(c), q};
  endfunction

  function automatic int exp_grant(input logic [N-1:0] mask);
    for (int j = 0; j < N; j++) begin
      if (mask[(tb_ptr + j) % N]) return (tb_ptr + j) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = d[i];
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_det_clr", det_clr, 0);
    chk("rst_w_out", w_out, 0);
    chk("rst_res_fields", {res_id, res_count, res_final_q}, 0);
    chk("rst_state", dbg_state, 0);
    Reset = 1'b1;
    tb_ptr = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  // One full request/result transaction; rdelay = cycles of res_ready=0.
  task automatic do_txn(input logic [N-1:0] mask, input int rdelay,
                        output int g, output int cnt, output int fq);
    int e, n, lat;
    logic [DW-1:0] word, wseen;
    logic [SB_W-1:0] exp_r;
    logic [IW-1:0] s_id;
    logic [CW-1:0] s_cnt;
    logic s_fq, stable;
    g = -1; cnt = -1; fq = -1;
    res_ready = (rdelay == 0);
    drive_data();
    req_valid = mask;
    e = exp_grant(mask);
    #1;
    n = 0;
    while (req_ready == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == '0) begin
      chk("grant_timeout", 0, 1);
      res_ready = 1'b1;
      return;
    end
    chk("grant_onehot", $countones(req_ready), 1);
    for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
    chk("grant_idx", g, e);
    word = d[g];
    exp_q.push_back({IW'(g), ref_det(word)});
    @(posedge clk); #1;
    tb_ptr = (g + 1) % N;
    req_valid[g] = 1'b0;
    chk("clr_cycle", {det_clr, busy, w_out}, 3'b110);
    lat = 0; wseen = '0;
    while (!res_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat >= 1 && lat <= DW) wseen[lat-1] = w_out;
    end
    if (!res_valid) begin
      chk("result_timeout", 0, 1);
      res_ready = 1'b1;
      return;
    end
    chk("latency", lat, DW + 2);
    chk("w_out_bits", wseen, word);
    s_id = res_id; s_cnt = res_count; s_fq = res_final_q; stable = 1'b1;
    for (int k = 0; k < rdelay; k++) begin
      @(negedge clk);
      if (!res_valid || res_id != s_id || res_count != s_cnt ||
          res_final_q != s_fq || req_ready != '0) stable = 1'b0;
    end
    if (rdelay > 0) chk("hold_stable", stable, 1);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      exp_r = exp_q.pop_front();
      chk("res_id", res_id, exp_r[CW+1 +: IW]);
      chk("res_count", res_count, exp_r[1 +: CW]);
      chk("res_final_q", res_final_q, exp_r[0]);
    end
    cnt = res_count; fq = res_final_q;
    if (rdelay > 0) begin
      @(negedge clk);
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("res_released", res_valid, 0);
    if (req_valid != '0) chk("next_grant", req_ready, 1 << exp_grant(req_valid));
  endtask

  typedef struct {
    int id;
    logic [DW-1:0] data;
    int exp_cnt;
    int exp_fq;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int g, c, f;
    int order [5];
    int rd;
    logic [N-1:0] m;

    tbl[0] = '{0, 8'h00, 7, 1};
    tbl[1] = '{2, 8'hFF, 8, 1};
    tbl[2] = '{2, 8'hAA, 4, 1};
    tbl[3] = '{2, 8'h55, 4, 0};
    tbl[4] = '{1, 8'h0F, 7, 1};
    tbl[5] = '{3, 8'h92, 5, 1};
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) d[i] = '0;
    req_data = '0;
    do_reset();

    // table-driven single-requester vectors
    for (int v = 0; v < 6; v++) begin
      d[tbl[v].id] = tbl[v].data;
      do_txn(N'(1) << tbl[v].id, 0, g, c, f);
      chk("tbl_id", g, tbl[v].id);
      chk("tbl_count", c, tbl[v].exp_cnt);
      chk("tbl_final_q", f, tbl[v].exp_fq);
    end

    // back-pressure with all others waiting (pointer is at 0 here)
    for (int i = 0; i < N; i++) d[i] = DW'($urandom);
    do_txn(4'b1111, 20, g, c, f);
    chk("bp_grant", g, 0);

    // pointer wrap: grant 3, then only 1 and 2 valid
    do_txn(4'b1000, 0, g, c, f);
    chk("wrap_first", g, 3);
    do_txn(4'b0110, 0, g, c, f);
    chk("wrap_grant", g, 1);

    // reset in the middle of SHIFT (k=4)
    d[2] = 8'h3C;
    drive_data();
    req_valid = 4'b0100;
    #1;
    chk("mid_pre_grant", req_ready, 4'b0100);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_in_shift", dbg_state, 2);
    Reset = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("mid_rst_outs", {busy, res_valid, det_clr, w_out}, 0);
    chk("mid_rst_ready", req_ready, 0);
    @(negedge clk);
    Reset = 1'b1;
    tb_ptr = 0;
    exp_q.delete();
    #1;
    chk("post_reset_grant", req_ready, 4'b0010);
    do_txn(4'b1010, 0, g, c, f);
    chk("post_reset_id", g, 1);

    // fairness from a fresh reset
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) d[i] = DW'($urandom);
      do_txn(4'b1111, 0, g, c, f);
      chk("fair_order", g, order[k]);
    end

    // randomized traffic against the model
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < N; i++) d[i] = DW'($urandom);
      m = N'($urandom_range(1, 15));
      rd = $urandom_range(0, 3);
      do_txn(m, rd, g, c, f);
    end

    req_valid = '0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
